// File: rtl/wb_scoreboard.sv
// Register-file write sequencer: tracks in-flight destination registers for the
// issue stage and merges the ALU and LSU writeback streams onto one write port.
module wb_scoreboard #(
    parameter int XLEN      = 32,
    parameter bit LSU_FIRST = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic [4:0]      issue_rd,
    input  logic            issue_rd_we,
    output logic            issue_ready,
    input  logic            alu_wb_valid,
    input  logic [4:0]      alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    input  logic            lsu_wb_valid,
    input  logic [4:0]      lsu_wb_rd,
    input  logic [XLEN-1:0] lsu_wb_data,
    output logic            lsu_wb_ready,
    output logic            rf_we,
    output logic [4:0]      rf_dst,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     busy_vec,
    output logic            wb_err
);

    logic [31:0]     busy_q, busy_d;
    logic            skid_vld_q, skid_vld_d;
    logic [4:0]      skid_rd_q, skid_rd_d;
    logic [XLEN-1:0] skid_data_q, skid_data_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_dst_q, rf_dst_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            wb_err_q, wb_err_d;

    logic            alu_acc, lsu_acc, issue_fire;
    logic            sel_vld;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    function automatic logic hazard(input logic [4:0] r, input logic [31:0] busy);
        return (r != 5'd0) && busy[r];
    endfunction

    assign issue_ready  = !(hazard(issue_rs1, busy_q) || hazard(issue_rs2, busy_q) ||
                            (issue_rd_we && hazard(issue_rd, busy_q)));
    assign issue_fire   = issue_valid && issue_ready;
    assign lsu_wb_ready = !skid_vld_q;
    assign alu_acc      = alu_wb_valid;
    assign lsu_acc      = lsu_wb_valid && !skid_vld_q;

    // Write selection: skid entry first (keeps per-stream order), then the
    // preferred stream; whichever accepted entry loses is parked in the skid.
    always_comb begin
        sel_vld     = 1'b0;
        sel_rd      = '0;
        sel_data    = '0;
        skid_vld_d  = skid_vld_q;
        skid_rd_d   = skid_rd_q;
        skid_data_d = skid_data_q;
        if (skid_vld_q) begin
            sel_vld     = 1'b1;
            sel_rd      = skid_rd_q;
            sel_data    = skid_data_q;
            skid_vld_d  = alu_acc;
            skid_rd_d   = alu_wb_rd;
            skid_data_d = alu_wb_data;
        end else if (alu_acc && lsu_acc) begin
            sel_vld    = 1'b1;
            skid_vld_d = 1'b1;
            if (LSU_FIRST) begin
                sel_rd      = lsu_wb_rd;
                sel_data    = lsu_wb_data;
                skid_rd_d   = alu_wb_rd;
                skid_data_d = alu_wb_data;
            end else begin
                sel_rd      = alu_wb_rd;
                sel_data    = alu_wb_data;
                skid_rd_d   = lsu_wb_rd;
                skid_data_d = lsu_wb_data;
            end
        end else if (alu_acc) begin
            sel_vld  = 1'b1;
            sel_rd   = alu_wb_rd;
            sel_data = alu_wb_data;
        end else if (lsu_acc) begin
            sel_vld  = 1'b1;
            sel_rd   = lsu_wb_rd;
            sel_data = lsu_wb_data;
        end
    end

    always_comb begin
        rf_we_d    = sel_vld && (sel_rd != 5'd0);
        rf_dst_d   = sel_vld ? sel_rd : rf_dst_q;
        rf_wdata_d = sel_vld ? sel_data : rf_wdata_q;
        wb_err_d   = wb_err_q || (sel_vld && (sel_rd != 5'd0) && !busy_q[sel_rd]);
        // Clear one edge after rf_we so the bit drops when the value is readable;
        // the issue set is applied last so it wins a same-edge collision.
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_dst_q] = 1'b0;
        end
        if (issue_fire && issue_rd_we && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            skid_vld_q  <= 1'b0;
            skid_rd_q   <= '0;
            skid_data_q <= '0;
            rf_we_q     <= 1'b0;
            rf_dst_q    <= '0;
            rf_wdata_q  <= '0;
            wb_err_q    <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            skid_vld_q  <= skid_vld_d;
            skid_rd_q   <= skid_rd_d;
            skid_data_q <= skid_data_d;
            rf_we_q     <= rf_we_d;
            rf_dst_q    <= rf_dst_d;
            rf_wdata_q  <= rf_wdata_d;
            wb_err_q    <= wb_err_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_dst   = rf_dst_q;
    assign rf_wdata = rf_wdata_q;
    assign busy_vec = busy_q;
    assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Bench for wb_scoreboard: directed scenarios plus randomized traffic checked
// against a queue-based model of the writeback merge and a busy bitmap.
module tb_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_rd_we;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_ready;
    logic        alu_wb_valid, lsu_wb_valid, lsu_wb_ready;
    logic [4:0]  alu_wb_rd, lsu_wb_rd;
    logic [31:0] alu_wb_data, lsu_wb_data;
    logic        rf_we, wb_err;
    logic [4:0]  rf_dst;
    logic [31:0] rf_wdata, busy_vec;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } wr_t;

    // Reference model state
    wr_t         m_q[$];
    logic [31:0] m_busy;
    logic        m_rf_we, m_err;
    logic [4:0]  m_rf_dst;
    logic [31:0] m_rf_wdata;

    wb_scoreboard #(.XLEN(32), .LSU_FIRST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_ready(issue_ready),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
        .lsu_wb_ready(lsu_wb_ready),
        .rf_we(rf_we), .rf_dst(rf_dst), .rf_wdata(rf_wdata),
        .busy_vec(busy_vec), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    function automatic logic m_ready();
        logic h1, h2, hd;
        h1 = (issue_rs1 != 0) && m_busy[issue_rs1];
        h2 = (issue_rs2 != 0) && m_busy[issue_rs2];
        hd = issue_rd_we && (issue_rd != 0) && m_busy[issue_rd];
        return !(h1 || h2 || hd);
    endfunction

    function automatic logic m_lsu_ready();
        return m_q.size() == 0;
    endfunction

    task automatic idle_inputs();
        issue_valid = 0; issue_rd_we = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
        lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
    endtask

    task automatic model_clear();
        m_q.delete();
        m_busy = 0; m_rf_we = 0; m_err = 0; m_rf_dst = 0; m_rf_wdata = 0;
    endtask

    // Advance one clock: the model consumes the current inputs, then outputs
    // settle 1 time unit after the edge.
    task automatic tick();
        logic        fire, lr;
        logic [31:0] nb;
        wr_t         w;
        fire = issue_valid && m_ready();
        lr   = m_lsu_ready();
        if (alu_wb_valid) begin
            w.rd = alu_wb_rd; w.d = alu_wb_data; m_q.push_back(w);
        end
        if (lsu_wb_valid && lr) begin
            w.rd = lsu_wb_rd; w.d = lsu_wb_data; m_q.push_back(w);
        end
        nb = m_busy;
        if (m_rf_we) nb[m_rf_dst] = 1'b0;
        if (fire && issue_rd_we && issue_rd != 0) nb[issue_rd] = 1'b1;
        if (m_q.size() > 0) begin
            w = m_q.pop_front();
            if (w.rd != 0 && !m_busy[w.rd]) m_err = 1'b1;
            m_rf_we = (w.rd != 0); m_rf_dst = w.rd; m_rf_wdata = w.d;
        end else begin
            m_rf_we = 1'b0;
        end
        m_busy = nb;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_clear();
        #3;
        checks++;
        if ({rf_we, rf_dst, rf_wdata, busy_vec, wb_err} !== '0) begin
            errors++; $display("FAIL reset_outputs: got we=%b dst=%0d wdata=%h busy=%h err=%b, want all 0",
                               rf_we, rf_dst, rf_wdata, busy_vec, wb_err);
        end
        checks++;
        if (issue_ready !== 1'b1 || lsu_wb_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got issue_ready=%b lsu_ready=%b, want 1 1", issue_ready, lsu_wb_ready);
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1;
        #1;
    endtask

    task automatic test_raw();
        do_reset();
        issue_valid = 1; issue_rd = 5; issue_rd_we = 1;
        tick();
        issue_valid = 0; issue_rd_we = 0; issue_rd = 0; issue_rs1 = 5;
        #1;
        checks++;
        if (busy_vec !== 32'h20) begin
            errors++; $display("FAIL raw_busy_set: got %h, want 00000020", busy_vec);
        end
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++; $display("FAIL raw_stall: got issue_ready=%b, want 0", issue_ready);
        end
        alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 32'hDEAD;
        tick();
        alu_wb_valid = 0;
        checks++;
        if (rf_we !== 1'b1 || rf_dst !== 5'd5 || rf_wdata !== 32'hDEAD) begin
            errors++; $display("FAIL raw_rf_write: got we=%b dst=%0d data=%h, want 1 5 0000dead", rf_we, rf_dst, rf_wdata);
        end
        checks++;
        if (busy_vec !== 32'h20 || issue_ready !== 1'b0) begin
            errors++; $display("FAIL raw_still_busy: got busy=%h ready=%b, want 00000020 0", busy_vec, issue_ready);
        end
        tick();
        checks++;
        if (busy_vec !== 32'h0 || issue_ready !== 1'b1 || rf_we !== 1'b0 || wb_err !== 1'b0) begin
            errors++; $display("FAIL raw_release: got busy=%h ready=%b we=%b err=%b, want 0 1 0 0",
                               busy_vec, issue_ready, rf_we, wb_err);
        end
        issue_rs1 = 0;
    endtask

    task automatic test_collision();
        do_reset();
        issue_valid = 1; issue_rd_we = 1; issue_rd = 3;
        tick();
        issue_rd = 4;
        tick();
        issue_valid = 0; issue_rd_we = 0; issue_rd = 0;
        alu_wb_valid = 1; alu_wb_rd = 3; alu_wb_data = 32'h11;
        lsu_wb_valid = 1; lsu_wb_rd = 4; lsu_wb_data = 32'h22;
        tick();
        alu_wb_valid = 0; lsu_wb_valid = 0;
        checks++;
        if (rf_we !== 1'b1 || rf_dst !== 5'd3 || rf_wdata !== 32'h11 || lsu_wb_ready !== 1'b0) begin
            errors++; $display("FAIL coll_first: got we=%b dst=%0d data=%h lsu_ready=%b, want 1 3 00000011 0",
                               rf_we, rf_dst, rf_wdata, lsu_wb_ready);
        end
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_dst !== 5'd4 || rf_wdata !== 32'h22 || lsu_wb_ready !== 1'b1) begin
            errors++; $display("FAIL coll_second: got we=%b dst=%0d data=%h lsu_ready=%b, want 1 4 00000022 1",
                               rf_we, rf_dst, rf_wdata, lsu_wb_ready);
        end
        checks++;
        if (busy_vec !== 32'h10) begin
            errors++; $display("FAIL coll_busy_mid: got %h, want 00000010", busy_vec);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || busy_vec !== 32'h0 || wb_err !== 1'b0) begin
            errors++; $display("FAIL coll_done: got we=%b busy=%h err=%b, want 0 0 0", rf_we, busy_vec, wb_err);
        end
    endtask

    task automatic test_x0();
        do_reset();
        issue_valid = 1; issue_rd_we = 1; issue_rd = 0;
        tick();
        issue_valid = 0; issue_rd_we = 0;
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++; $display("FAIL x0_busy: got %h, want 0", busy_vec);
        end
        alu_wb_valid = 1; alu_wb_rd = 0; alu_wb_data = 32'h1234;
        tick();
        alu_wb_valid = 0;
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL x0_no_we: got rf_we=%b, want 0", rf_we);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || wb_err !== 1'b0 || busy_vec !== 32'h0) begin
            errors++; $display("FAIL x0_after: got we=%b err=%b busy=%h, want 0 0 0", rf_we, wb_err, busy_vec);
        end
    endtask

    task automatic test_wb_err();
        do_reset();
        lsu_wb_valid = 1; lsu_wb_rd = 7; lsu_wb_data = 32'h77;
        tick();
        lsu_wb_valid = 0;
        checks++;
        if (rf_we !== 1'b1 || rf_dst !== 5'd7 || rf_wdata !== 32'h77 || wb_err !== 1'b1) begin
            errors++; $display("FAIL err_set: got we=%b dst=%0d data=%h err=%b, want 1 7 00000077 1",
                               rf_we, rf_dst, rf_wdata, wb_err);
        end
        repeat (4) tick();
        checks++;
        if (wb_err !== 1'b1) begin
            errors++; $display("FAIL err_sticky: got %b, want 1", wb_err);
        end
        do_reset();
        checks++;
        if (wb_err !== 1'b0) begin
            errors++; $display("FAIL err_cleared: got %b, want 0", wb_err);
        end
    endtask

    task automatic test_waw();
        do_reset();
        issue_valid = 1; issue_rd_we = 1; issue_rd = 9;
        tick();
        checks++;
        if (busy_vec !== 32'h200 || issue_ready !== 1'b0) begin
            errors++; $display("FAIL waw_stall: got busy=%h ready=%b, want 00000200 0", busy_vec, issue_ready);
        end
        alu_wb_valid = 1; alu_wb_rd = 9; alu_wb_data = 32'h99;
        tick();
        alu_wb_valid = 0;
        checks++;
        if (issue_ready !== 1'b0 || rf_we !== 1'b1 || rf_dst !== 5'd9) begin
            errors++; $display("FAIL waw_writing: got ready=%b we=%b dst=%0d, want 0 1 9", issue_ready, rf_we, rf_dst);
        end
        tick();
        checks++;
        if (issue_ready !== 1'b1 || busy_vec !== 32'h0) begin
            errors++; $display("FAIL waw_release: got ready=%b busy=%h, want 1 0", issue_ready, busy_vec);
        end
        tick();
        issue_valid = 0; issue_rd_we = 0; issue_rd = 0;
        checks++;
        if (busy_vec !== 32'h200 || wb_err !== 1'b0) begin
            errors++; $display("FAIL waw_reissue: got busy=%h err=%b, want 00000200 0", busy_vec, wb_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        alu_wb_valid = 1; alu_wb_rd = 3; alu_wb_data = 32'h33;
        lsu_wb_valid = 1; lsu_wb_rd = 4; lsu_wb_data = 32'h44;
        tick();
        idle_inputs();
        checks++;
        if (lsu_wb_ready !== 1'b0 || rf_we !== 1'b1) begin
            errors++; $display("FAIL mid_skid_full: got lsu_ready=%b we=%b, want 0 1", lsu_wb_ready, rf_we);
        end
        #1;
        rst_n = 0;
        model_clear();
        #1;
        checks++;
        if ({rf_we, rf_dst, rf_wdata, busy_vec, wb_err} !== '0 || lsu_wb_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset_outputs: got we=%b dst=%0d data=%h busy=%h err=%b lsu_ready=%b, want 0s and ready 1",
                               rf_we, rf_dst, rf_wdata, busy_vec, wb_err, lsu_wb_ready);
        end
        @(posedge clk);
        #2;
        rst_n = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rf_we !== 1'b0) begin
                errors++; $display("FAIL mid_no_we_after: cycle %0d got rf_we=%b, want 0", i, rf_we);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            issue_valid  = ($urandom_range(0, 99) < 50);
            issue_rs1    = 5'($urandom_range(0, 7));
            issue_rs2    = 5'($urandom_range(0, 7));
            issue_rd     = 5'($urandom_range(0, 7));
            issue_rd_we  = ($urandom_range(0, 99) < 70);
            alu_wb_valid = ($urandom_range(0, 99) < 35);
            alu_wb_rd    = 5'($urandom_range(0, 7));
            alu_wb_data  = $urandom;
            lsu_wb_valid = ($urandom_range(0, 99) < 35);
            lsu_wb_rd    = 5'($urandom_range(0, 7));
            lsu_wb_data  = $urandom;
            #1;
            checks++;
            if (issue_ready !== m_ready() || lsu_wb_ready !== m_lsu_ready()) begin
                errors++; $display("FAIL rnd_ready c=%0d: got issue=%b lsu=%b, want %b %b",
                                   c, issue_ready, lsu_wb_ready, m_ready(), m_lsu_ready());
            end
            tick();
            checks++;
            if (rf_we !== m_rf_we || rf_dst !== m_rf_dst || rf_wdata !== m_rf_wdata) begin
                errors++; $display("FAIL rnd_rf c=%0d: got we=%b dst=%0d data=%h, want %b %0d %h",
                                   c, rf_we, rf_dst, rf_wdata, m_rf_we, m_rf_dst, m_rf_wdata);
            end
            checks++;
            if (busy_vec !== m_busy || wb_err !== m_err) begin
                errors++; $display("FAIL rnd_state c=%0d: got busy=%h err=%b, want %h %b",
                                   c, busy_vec, wb_err, m_busy, m_err);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_collision();
        test_x0();
        test_wb_err();
        test_waw();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
